// File: rtl/llpm_router_buffered.sv
// llpm_router_buffered: 1-to-N steering vertex. One token per cycle enters on x and
// is steered by x_sel into a one-entry registered slot per output; each slot drains
// independently under its own backpressure. Tokens addressed past the last output
// are swallowed and reported through a sticky flag and a saturating drop counter.
module llpm_router_buffered #(
  parameter int Width           = 8,
  parameter int NumOutputs      = 4,
  parameter int CLog2NumOutputs = 2,
  parameter int CountWidth      = 8
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic [Width-1:0]           x,
  input  logic [CLog2NumOutputs-1:0] x_sel,
  input  logic                       x_valid,
  output logic                       x_bp,
  output logic [Width-1:0]           a       [NumOutputs-1:0],
  output logic                       a_valid [NumOutputs-1:0],
  input  logic                       a_bp    [NumOutputs-1:0],
  output logic                       err_badsel,
  input  logic                       err_clr,
  output logic [CountWidth-1:0]      drop_count
);

  localparam logic [CLog2NumOutputs:0] NumOutputsW = (CLog2NumOutputs + 1)'(NumOutputs);
  localparam logic [CountWidth-1:0]    CountMax    = {CountWidth{1'b1}};

  logic [NumOutputs-1:0] full_q;
  logic [NumOutputs-1:0] full_d;
  logic [Width-1:0]      data_q [NumOutputs-1:0];
  logic [Width-1:0]      data_d [NumOutputs-1:0];
  logic                  err_q;
  logic                  err_d;
  logic [CountWidth-1:0] cnt_q;
  logic [CountWidth-1:0] cnt_d;

  logic                  in_range_s;
  logic                  sel_blocked_s;
  logic                  accept_s;
  logic                  bad_accept_s;
  logic [NumOutputs-1:0] load_s;

  // Extra leading zero keeps the range check correct when NumOutputs is a power of two.
  assign in_range_s = ({1'b0, x_sel} < NumOutputsW);

  // Stall condition of the addressed slot, built by match so x_sel never indexes past the slots.
  always_comb begin
    sel_blocked_s = 1'b0;
    for (int i = 0; i < NumOutputs; i++) begin
      sel_blocked_s = sel_blocked_s |
                      ((x_sel == CLog2NumOutputs'(i)) & full_q[i] & a_bp[i]);
    end
  end

  // A slot that drains this cycle can reload, so only a full-and-stalled slot pushes back.
  assign x_bp         = ~resetn | (in_range_s & sel_blocked_s);
  assign accept_s     = x_valid & ~x_bp;
  assign bad_accept_s = accept_s & ~in_range_s;

  // Per-slot next state: a load overrides a concurrent drain; otherwise the slot empties on drain.
  always_comb begin
    full_d = full_q;
    data_d = data_q;
    load_s = '0;
    for (int i = 0; i < NumOutputs; i++) begin
      load_s[i] = accept_s & (x_sel == CLog2NumOutputs'(i));
      if (load_s[i]) begin
        full_d[i] = 1'b1;
        data_d[i] = x;
      end else begin
        full_d[i] = full_q[i] & a_bp[i];
        data_d[i] = data_q[i];
      end
    end
  end

  // Error bookkeeping: a bad-select drop takes priority over a clear in the same cycle.
  always_comb begin
    err_d = err_q;
    cnt_d = cnt_q;
    if (bad_accept_s) begin
      err_d = 1'b1;
      if (err_clr) begin
        cnt_d = CountWidth'(1);
      end else if (cnt_q == CountMax) begin
        cnt_d = cnt_q;
      end else begin
        cnt_d = cnt_q + CountWidth'(1);
      end
    end else if (err_clr) begin
      err_d = 1'b0;
      cnt_d = '0;
    end else begin
      err_d = err_q;
      cnt_d = cnt_q;
    end
  end

  // State registers; reset discards any tokens held in the slots.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      full_q <= '0;
      for (int i = 0; i < NumOutputs; i++) begin
        data_q[i] <= '0;
      end
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      full_q <= full_d;
      for (int i = 0; i < NumOutputs; i++) begin
        data_q[i] <= data_d[i];
      end
      err_q <= err_d;
      cnt_q <= cnt_d;
    end
  end

  // Outputs come straight from the slot registers.
  for (genvar g = 0; g < NumOutputs; g++) begin : g_out
    assign a[g]       = data_q[g];
    assign a_valid[g] = full_q[g];
  end

  assign err_badsel = err_q;
  assign drop_count = cnt_q;

endmodule

// File: doc/llpm_router_buffered.md
Name: llpm_router_buffered

Overview:
- 1-to-N steering vertex: the fan-out counterpart to the LLPM select/merge vertex.
- Accepts one token per cycle on a single input channel, tagged with a destination index, and delivers it on the indexed output channel.
- Each output has a one-entry registered slot, so outputs are register-driven and each drains independently under its own backpressure.
- Used at the split side of arbitrated/shared resources, e.g. returning responses to the requester that a select vertex merged.

Parameters:
Width, 8, data bits per token
NumOutputs, 4, number of output channels (>=2, need not be a power of two)
CLog2NumOutputs, 2, width of destination index; must equal ceil(log2(NumOutputs))
CountWidth, 8, width of the dropped-token counter

Ports:
clk  input  1  clock; all state updates on rising edge
resetn  input  1  asynchronous active-low reset
x  input  Width  input token data
x_sel  input  CLog2NumOutputs  destination output index for x
x_valid  input  1  input token present
x_bp  output  1  input backpressure (1 = not accepted this cycle)
a  output  Width x NumOutputs (unpacked array [NumOutputs-1:0])  per-output data
a_valid  output  1 x NumOutputs (unpacked array)  per-output token present
a_bp  input  1 x NumOutputs (unpacked array)  per-output backpressure
err_badsel  output  1  sticky: a token with x_sel >= NumOutputs was dropped
err_clr  input  1  synchronous clear of err_badsel and drop_count
drop_count  output  CountWidth  saturating count of dropped tokens

Behaviour:
- Handshake (all channels): transfer occurs in a cycle iff valid=1 and bp=0. Producer may change data/sel/valid freely while bp=1; there is no hold requirement.
- State: per output i, full[i] and data[i]; plus err_badsel and drop_count.
- Outputs: a_valid[i]=full[i] and a[i]=data[i], both direct from registers.
- Combinational paths: none from x/x_valid to any a/a_valid. The only combinational path is to x_bp.
- drain[i] = full[i] & ~a_bp[i].
- For in-range x_sel: x_bp = ~resetn | (full[x_sel] & a_bp[x_sel]).
  - A full slot being drained in the same cycle can accept, giving throughput of 1 token/cycle per output.
- For out-of-range x_sel (>= NumOutputs): x_bp = ~resetn. The token is always accepted and discarded.
- x_bp is a function of x_sel, full, a_bp and resetn only, never of x_valid.
- Accept, in range: next full[x_sel]=1 and data[x_sel]=x. The token appears on a[x_sel] with a_valid the cycle after acceptance (latency 1).
- Drain without load: full[i] goes to 0. Data register is don't-care but holds its value.
- Simultaneous drain and load on the same slot: load wins. full stays 1, data updates, and back-to-back tokens are delivered on consecutive cycles.
- Slots not addressed by x_sel are unaffected by input activity. Per-output ordering is preserved; there is no ordering guarantee across outputs.
- Accept, out of range: err_badsel <= 1 and drop_count increments, saturating at all-ones (no wrap).
- err_clr=1 clears err_badsel and drop_count to 0.
  - If a bad-select accept occurs in the same cycle, the result is err_badsel=1 and drop_count=1 (set wins over clear).
- With NumOutputs a power of two, the out-of-range path is unreachable. err_badsel stays 0 and drop_count stays 0.
- Reset (asynchronous assert, any time including mid-transfer):
  - all full=0, so all a_valid=0;
  - all data=0, so a=0;
  - err_badsel=0, drop_count=0;
  - x_bp=1 while resetn=0.
  - Tokens held in slots are lost. Operation resumes on the first clk edge after resetn deasserts. x_bp follows the in-range/out-of-range rules combinationally from deassertion.
- x_sel is ignored when x_valid=0. An X on x_sel with x_valid=0 must not corrupt state.

Test Plan:
- Reset release, x_valid=1, x=0x5A, x_sel=2, all a_bp=0 -> x_bp=0. Next cycle a_valid[2]=1 with a[2]=0x5A, all other a_valid=0. One cycle later a_valid[2]=0.
- a_bp[1]=1 held; send 0x11 then 0x22 to sel=1 -> 0x11 accepted. x_bp=1 for the second token while a_bp[1]=1. Meanwhile 0x33 to sel=3 is accepted and delivered (no cross-output blocking). Drop a_bp[1] -> 0x22 is accepted that same cycle, and a[1]=0x22 appears the following cycle.
- Streaming 0x01..0x08 to sel=0 with a_bp[0]=0 every cycle -> x_bp=0 throughout. a[0] shows 0x01..0x08 on 8 consecutive cycles with a_valid[0]=1 continuously.
- NumOutputs=3, CLog2NumOutputs=2, x_sel=3, 300 accepted tokens, CountWidth=8 -> x_bp=0, no a_valid asserted, err_badsel=1, drop_count saturates at 255.
- From the previous state, err_clr=1 on the same cycle as another sel=3 accept -> err_badsel=1 and drop_count=1 next cycle. err_clr alone next -> both 0.
- Slots 0 and 2 full with a_bp held high; assert resetn=0 mid-cycle -> immediately a_valid all 0, a all 0, x_bp=1. After deassert, a sel=0 token is accepted on the first edge.
